// File: rtl/color_pkg.sv
// Shared types and constants for the colour sequencer and its LFSR.
package color_pkg;

    localparam int unsigned NUM_COLORS   = 6;
    localparam int unsigned COLOR_W      = 3;
    localparam int unsigned LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    // One Galois step: shift right, fold the taps back in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/color_lfsr.sv
// 16-bit Galois LFSR colour source; a zero load value is replaced by SEED
// because the all-zero state would lock the generator.
module color_lfsr
    import color_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_value == 16'h0000) ? SEED : load_value;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Colour stream generator: LFSR candidates, range/repeat filter, preview FIFO
// with valid/ready pop, and the IDLE/FILL/FULL refill scheduler.
module color_sequencer
    import color_pkg::*;
#(
    parameter int unsigned NUM_COLORS  = color_pkg::NUM_COLORS,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned MAX_REPEAT  = 2,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 seed_load,
    input  logic [15:0]                          seed_in,
    input  logic                                 color_ready,
    output logic                                 color_valid,
    output logic [2:0]                           color_out,
    output logic [2:0]                           preview_color,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned RUN_W = $clog2(MAX_REPEAT + 1);

    state_t             state;
    state_t             state_next;

    color_t             q [QUEUE_DEPTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    color_t             last_color;
    logic [RUN_W-1:0]   run_len;

    logic [15:0]        lfsr_value;
    color_t             cand;
    logic               cand_legal;
    logic               run_full;
    logic               has_room;
    logic               step;
    logic               push;
    logic               pop;
    logic [IDX_W-1:0]   wr_idx;

    color_lfsr #(
        .SEED       (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (step),
        .load       (seed_load),
        .load_value (seed_in),
        .state      (lfsr_value)
    );

    // Only the low bits form a candidate; the rest just feed the generator.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_value[15:3];

    // Candidate filter, handshake and occupancy bookkeeping.
    always_comb begin
        cand        = lfsr_value[2:0];
        has_room    = (count < CNT_W'(QUEUE_DEPTH));
        cand_legal  = (32'(cand) < NUM_COLORS);
        run_full    = (run_len == RUN_W'(MAX_REPEAT)) && (cand == last_color);
        // The generator only advances when the result could be stored, so the
        // accepted sequence is independent of back-pressure timing.
        step        = (state == FILL) && enable && !seed_load && has_room;
        push        = step && cand_legal && !run_full;
        color_valid = (count != '0) && !seed_load;
        pop         = color_valid && color_ready;
        wr_idx      = IDX_W'(pop ? (count - CNT_W'(1)) : count);
        count_next  = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Refill scheduler next state.
    always_comb begin
        state_next = state;
        if (seed_load) begin
            state_next = enable ? FILL : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state_next = FILL;
                end
                FILL: begin
                    if (!enable)                                 state_next = IDLE;
                    else if (count_next == CNT_W'(QUEUE_DEPTH)) state_next = FULL;
                end
                FULL: begin
                    if (!enable)       state_next = IDLE;
                    else if (has_room) state_next = FILL;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift-register FIFO: q[0] is the head, unused slots are kept at zero.
    always_ff @(posedge clk) begin
        if (!reset_n || seed_load) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q[i] <= '0;
            end
            count      <= '0;
            last_color <= '0;
            run_len    <= '0;
        end else begin
            count <= count_next;
            if (pop) begin
                for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
                    q[i] <= q[i+1];
                end
                q[QUEUE_DEPTH-1] <= '0;
            end
            if (push) begin
                q[wr_idx]  <= cand;
                last_color <= cand;
                run_len    <= ((run_len != '0) && (cand == last_color))
                              ? (run_len + RUN_W'(1)) : RUN_W'(1);
            end
        end
    end

    assign color_out     = q[0];
    assign preview_color = q[1];
    assign queue_count   = count;

endmodule
